// File: rtl/exec_unit_if.sv
// rtl/exec_unit_if.sv - issue and register-file write-back bundle for exec_unit
interface exec_unit_if #(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 2
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            op;
  logic [DATA_W-1:0]     src_a;
  logic [DATA_W-1:0]     src_b;
  logic [REG_ADDR_W-1:0] dst_reg;
  logic                  wr_en;
  logic [REG_ADDR_W-1:0] wr_reg;
  logic [DATA_W-1:0]     wr_value;
  logic                  busy;
  logic                  flag_c;
  logic                  flag_z;

  modport master (
    output in_valid, op, src_a, src_b, dst_reg,
    input  in_ready, wr_en, wr_reg, wr_value, busy, flag_c, flag_z
  );

  modport slave (
    input  in_valid, op, src_a, src_b, dst_reg,
    output in_ready, wr_en, wr_reg, wr_value, busy, flag_c, flag_z
  );
endinterface

// File: rtl/exec_unit.sv
// rtl/exec_unit.sv - execute/writeback stage: single-cycle ALU plus iterative shift-add multiply
// The multiplier (MUL/MULH, states MUL/WB) is built only when EXEC_UNIT_MUL_EN is defined.
module exec_unit #(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 2
) (
  input  logic       clk,
  input  logic       reset,
  exec_unit_if.slave bus
);
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;

  logic                  wr_en_q;
  logic [REG_ADDR_W-1:0] wr_reg_q;
  logic [DATA_W-1:0]     wr_value_q;
  logic                  flag_c_q;
  logic                  flag_z_q;
  logic                  ready;
  logic                  busy_w;
  logic                  accept;
  logic                  single_accept;
  logic [DATA_W-1:0]     alu_value;
  logic                  alu_c;

  assign accept = bus.in_valid && ready;

  // Shifts are done one bit wider so the last bit shifted out lands in the carry slot.
  always_comb begin
    alu_value = '0;
    alu_c     = 1'b0;
    case (bus.op)
      OP_ADD: {alu_c, alu_value} = {1'b0, bus.src_a} + {1'b0, bus.src_b};
      OP_SUB: begin
        alu_value = bus.src_a - bus.src_b;
        alu_c     = (bus.src_a < bus.src_b);
      end
      OP_AND: alu_value = bus.src_a & bus.src_b;
      OP_XOR: alu_value = bus.src_a ^ bus.src_b;
      OP_SHL: {alu_c, alu_value} = {1'b0, bus.src_a} << bus.src_b[2:0];
      OP_SHR: {alu_value, alu_c} = {bus.src_a, 1'b0} >> bus.src_b[2:0];
      default: ;
    endcase
  end

`ifdef EXEC_UNIT_MUL_EN
  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {IDLE, MUL, WB} state_t;

  state_t                state_q;
  state_t                state_d;
  logic [2*DATA_W-1:0]   acc_q;
  logic [2*DATA_W-1:0]   mcand_q;
  logic [2*DATA_W-1:0]   acc_next;
  logic [DATA_W-1:0]     mplier_q;
  logic [DATA_W-1:0]     mul_value;
  logic [CNT_W-1:0]      cnt_q;
  logic                  high_q;
  logic [REG_ADDR_W-1:0] dst_q;
  logic                  is_mul;
  logic                  last_step;

  assign is_mul        = (bus.op[2:1] == 2'b11);
  assign single_accept = accept && !is_mul;
  assign last_step     = (cnt_q == CNT_W'(DATA_W - 1));
  assign acc_next      = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_value     = high_q ? acc_next[2*DATA_W-1:DATA_W] : acc_next[DATA_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    busy_w  = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.in_valid && is_mul) state_d = MUL;
      end
      MUL: begin
        busy_w = 1'b1;
        if (last_step) state_d = WB;
      end
      WB: begin
        busy_w  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Multiplicand walks left while the multiplier walks right, one partial product per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      high_q   <= 1'b0;
      dst_q    <= '0;
    end else if (accept && is_mul) begin
      acc_q    <= '0;
      mcand_q  <= {{DATA_W{1'b0}}, bus.src_a};
      mplier_q <= bus.src_b;
      cnt_q    <= '0;
      high_q   <= bus.op[0];
      dst_q    <= bus.dst_reg;
    end else if (state_q == MUL) begin
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
    end
  end
`else
  assign ready         = 1'b1;
  assign busy_w        = 1'b0;
  assign single_accept = accept;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en_q    <= 1'b0;
      wr_reg_q   <= '0;
      wr_value_q <= '0;
      flag_c_q   <= 1'b0;
      flag_z_q   <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      if (single_accept) begin
        wr_en_q    <= 1'b1;
        wr_reg_q   <= bus.dst_reg;
        wr_value_q <= alu_value;
        flag_c_q   <= alu_c;
        flag_z_q   <= (alu_value == '0);
      end
`ifdef EXEC_UNIT_MUL_EN
      // Final step writes straight from the adder so WB carries the finished product.
      if (state_q == MUL && last_step) begin
        wr_en_q    <= 1'b1;
        wr_reg_q   <= dst_q;
        wr_value_q <= mul_value;
        flag_c_q   <= |acc_next[2*DATA_W-1:DATA_W];
        flag_z_q   <= (mul_value == '0);
      end
`endif
    end
  end

  assign bus.in_ready = ready;
  assign bus.busy     = busy_w;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_reg   = wr_reg_q;
  assign bus.wr_value = wr_value_q;
  assign bus.flag_c   = flag_c_q;
  assign bus.flag_z   = flag_z_q;
endmodule

// File: tb/tb_exec_unit.sv
// tb/tb_exec_unit.sv - randomized scoreboard bench for exec_unit against an arithmetic reference model
module tb_exec_unit;
  localparam int DATA_W     = 8;
  localparam int REG_ADDR_W = 2;
`ifdef EXEC_UNIT_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  exec_unit_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) bus ();

  exec_unit #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct {
    int cyc;
    int rg;
    int val;
    int c;
    int z;
  } exp_t;

  exp_t sb[$];
  int   n_checks   = 0;
  int   n_pass     = 0;
  int   ready_from = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Behavioural reference: plain integer arithmetic on the operand values.
  function automatic void ref_model(input int op, input int a, input int b,
                                    output int val, output int c);
    int n;
    int p;
    n = b % 8;
    p = a * b;
    val = 0;
    c   = 0;
    case (op)
      0: begin val = (a + b) % 256;        c = ((a + b) > 255) ? 1 : 0; end
      1: begin val = (a - b + 256) % 256;  c = (a < b) ? 1 : 0; end
      2: val = a & b;
      3: val = a ^ b;
      4: begin val = (a * (1 << n)) % 256; c = (n == 0) ? 0 : ((a >> (8 - n)) & 1); end
      5: begin val = a >> n;               c = (n == 0) ? 0 : ((a >> (n - 1)) & 1); end
      default: begin
        if (MUL_EN) begin
          val = (op == 6) ? (p % 256) : (p / 256);
          c   = (p > 255) ? 1 : 0;
        end
      end
    endcase
  endfunction

  task automatic push(input int op, input int a, input int b, input int d);
    exp_t e;
    bit   slow;
    ref_model(op, a, b, e.val, e.c);
    e.z  = (e.val == 0) ? 1 : 0;
    e.rg = d;
    slow = MUL_EN && (op >= 6);
    e.cyc = slow ? cyc + DATA_W : cyc;
    if (slow) ready_from = cyc + DATA_W + 1;
    sb.push_back(e);
  endtask

  task automatic drive(input bit v, input int op, input int a, input int b, input int d,
                       output bit acc);
    bit exp_ready;
    bus.in_valid = v;
    bus.op       = 3'(op);
    bus.src_a    = 8'(a);
    bus.src_b    = 8'(b);
    bus.dst_reg  = 2'(d);
    @(negedge clk);
    exp_ready = (cyc >= ready_from);
    check("in_ready", int'(bus.in_ready), int'(exp_ready));
    check("busy", int'(bus.busy), int'(MUL_EN && !exp_ready));
    @(posedge clk);
    #1;
    acc = v && exp_ready;
    if (acc) push(op, a, b, d);
  endtask

  task automatic issue(input int op, input int a, input int b, input int d);
    bit acc;
    int guard;
    guard = 0;
    do begin
      drive(1'b1, op, a, b, d, acc);
      guard++;
    end while (!acc && guard < 50);
    if (!acc) check("issue_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++)
      drive(1'b0, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), acc);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (bus.wr_en) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL spurious_write: wr_en=1 wr_value=0x%0h expected no write (cycle %0d)",
                   bus.wr_value, cyc);
        end else begin
          e = sb.pop_front();
          check("wr_cycle", cyc, e.cyc);
          check("wr_reg", int'(bus.wr_reg), e.rg);
          check("wr_value", int'(bus.wr_value), e.val);
          check("flag_c", int'(bus.flag_c), e.c);
          check("flag_z", int'(bus.flag_z), e.z);
        end
      end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        n_checks++;
        $display("FAIL missing_write: wr_en=0 expected write of 0x%0h at cycle %0d (now %0d)",
                 e.val, e.cyc, cyc);
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.op       = '0;
    bus.src_a    = '0;
    bus.src_b    = '0;
    bus.dst_reg  = '0;
    repeat (2) @(negedge clk);
    check("rst_wr_en", int'(bus.wr_en), 0);
    check("rst_wr_reg", int'(bus.wr_reg), 0);
    check("rst_wr_value", int'(bus.wr_value), 0);
    check("rst_flags", int'({bus.flag_c, bus.flag_z}), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1 reset = 1'b0;

    issue(0, 8'hF0, 8'h20, 2);
    issue(1, 8'h05, 8'h05, 1);
    issue(1, 8'h03, 8'h05, 0);
    issue(4, 8'h81, 8'h01, 3);
    issue(5, 8'h81, 8'h09, 2);
    issue(4, 8'h81, 8'h00, 1);
    idle(2);
    issue(6, 8'h12, 8'h34, 3);
    issue(7, 8'hFF, 8'hFF, 0);
    issue(0, 8'h11, 8'h22, 1);
    idle(3);

    issue(6, 8'h12, 8'h34, 1);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_wr_en", int'(bus.wr_en), 0);
    check("abort_wr_value", int'(bus.wr_value), 0);
    check("abort_flags", int'({bus.flag_c, bus.flag_z}), 0);
    check("abort_busy", int'(bus.busy), 0);
    sb.delete();
    ready_from = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle(12);
    issue(0, 8'h01, 8'h01, 2);
    idle(2);

    for (int i = 0; i < 200; i++) begin
      issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end

    for (int i = 0; i < 40 && sb.size() > 0; i++) idle(1);
    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
